// File: rtl/ctrl_pulse_pkg.sv
// Shared constants for the control-register pulse sequencer: FSM encoding,
// control-bit field positions and counter widths.
package ctrl_pulse_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;

    localparam int START_BIT = 7;
    localparam int ABORT_BIT = 6;
    localparam int W_MSB     = 5;
    localparam int W_LSB     = 3;
    localparam int N_MSB     = 2;
    localparam int N_LSB     = 0;

    localparam int GCNT_W    = 4;

endpackage

// File: rtl/ctrl_edge_sync.sv
// Conditions control_in for the FSM: optional 2-flop synchronizer
// (enabled by `CTRL_PULSE_SYNC_EN), start rising-edge detect and field extraction.
module ctrl_edge_sync
    import ctrl_pulse_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] control_in,
    output logic       start_edge_o,
    output logic       abort_o,
    output logic [2:0] w_o,
    output logic [2:0] n_o
);

    logic [7:0] ctrl_s;
    logic       start_prev_q;

`ifdef CTRL_PULSE_SYNC_EN
    logic [7:0] sync1_q;
    logic [7:0] sync2_q;

    // Reset value keeps start high so a held start bit cannot fire out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 8'h80;
            sync2_q <= 8'h80;
        end else begin
            sync1_q <= control_in;
            sync2_q <= sync1_q;
        end
    end

    assign ctrl_s = sync2_q;
`else
    assign ctrl_s = control_in;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            start_prev_q <= 1'b1;
        end else begin
            start_prev_q <= ctrl_s[START_BIT];
        end
    end

    assign start_edge_o = ctrl_s[START_BIT] & ~start_prev_q;
    assign abort_o      = ctrl_s[ABORT_BIT];
    assign w_o          = ctrl_s[W_MSB:W_LSB];
    assign n_o          = ctrl_s[N_MSB:N_LSB];

endmodule

// File: rtl/ctrl_pulse_sequencer.sv
// Turns a firmware start write into a pulse train of N+1 pulses, each W+1 cycles
// high, separated by GAP_CYCLES; `CTRL_PULSE_SYNC_EN adds an input synchronizer.
module ctrl_pulse_sequencer
    import ctrl_pulse_pkg::*;
#(
    parameter int   GAP_CYCLES = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] control_in,
    output logic       pulse_out,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [2:0] pulse_idx
);

    localparam logic [GCNT_W-1:0] GAP_LAST = GCNT_W'(GAP_CYCLES - 1);

    logic       start_edge;
    logic       abort;
    logic [2:0] w_field;
    logic [2:0] n_field;

    logic [1:0]        state_q, state_d;
    logic [2:0]        hcnt_q, hcnt_d;
    logic [GCNT_W-1:0] gcnt_q, gcnt_d;
    logic [2:0]        w_q, w_d;
    logic [2:0]        n_q, n_d;
    logic [2:0]        idx_q, idx_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;

    ctrl_edge_sync u_edge_sync (
        .clock        (clock),
        .reset        (reset),
        .control_in   (control_in),
        .start_edge_o (start_edge),
        .abort_o      (abort),
        .w_o          (w_field),
        .n_o          (n_field)
    );

    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        gcnt_d    = gcnt_q;
        w_d       = w_q;
        n_d       = n_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        case (state_q)
            IDLE: begin
                // Abort in IDLE suppresses a simultaneous start and raises no strobe.
                if (start_edge && !abort) begin
                    state_d = HIGH;
                    w_d     = w_field;
                    n_d     = n_field;
                    hcnt_d  = 3'd0;
                    idx_d   = 3'd0;
                end
            end
            HIGH: begin
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (hcnt_q == w_q) begin
                    if (idx_q == n_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LOW;
                        gcnt_d  = '0;
                    end
                end else begin
                    hcnt_d = hcnt_q + 3'd1;
                end
            end
            LOW: begin
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (gcnt_q == GAP_LAST) begin
                    state_d = HIGH;
                    hcnt_d  = 3'd0;
                    idx_d   = idx_q + 3'd1;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            hcnt_q    <= 3'd0;
            gcnt_q    <= '0;
            w_q       <= 3'd0;
            n_q       <= 3'd0;
            idx_q     <= 3'd0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            gcnt_q    <= gcnt_d;
            w_q       <= w_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign pulse_out = (state_q == HIGH) ? ~IDLE_LEVEL : IDLE_LEVEL;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign pulse_idx = idx_q;

endmodule

// File: tb/tb_ctrl_pulse_sequencer.sv
// Directed bench for ctrl_pulse_sequencer in its default build (no synchronizer),
// GAP_CYCLES=2, IDLE_LEVEL=0.
module tb_ctrl_pulse_sequencer;

    logic       clock;
    logic       reset;
    logic [7:0] control_in;
    logic       pulse_out;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [2:0] pulse_idx;
    logic [6:0] obs;

    int checks = 0;
    int errors = 0;

    ctrl_pulse_sequencer #(
        .GAP_CYCLES (2),
        .IDLE_LEVEL (1'b0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .control_in (control_in),
        .pulse_out  (pulse_out),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .pulse_idx  (pulse_idx)
    );

    // Observed vector: {pulse_out, busy, done, aborted, pulse_idx}
    assign obs = {pulse_out, busy, done, aborted, pulse_idx};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Expected vector for a W=3, N=2 train at cycle c after the edge-sample cycle.
    function automatic logic [6:0] exp_w3n2(input int c);
        logic       hi;
        logic [2:0] idx;
        hi  = (c >= 1 && c <= 4) || (c >= 7 && c <= 10) || (c >= 13 && c <= 16);
        idx = (c <= 6) ? 3'd0 : ((c <= 12) ? 3'd1 : 3'd2);
        return {hi, (c <= 16), (c == 17), 1'b0, idx};
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        control_in = 8'h00;
        tick;
        tick;
        checks++;
        if (obs !== 7'b0000000) begin
            errors++;
            $display("FAIL reset_hold got %b exp %b", obs, 7'b0000000);
        end
        reset = 1'b0;
        tick;
        checks++;
        if (obs !== 7'b0000000) begin
            errors++;
            $display("FAIL reset_release got %b exp %b", obs, 7'b0000000);
        end
    endtask

    task automatic test_single;
        logic [6:0] exp_v [1:3];
        exp_v[1] = 7'b1100000;
        exp_v[2] = 7'b0010000;
        exp_v[3] = 7'b0000000;
        control_in = 8'h80;
        for (int c = 1; c <= 3; c++) begin
            tick;
            checks++;
            if (obs !== exp_v[c]) begin
                errors++;
                $display("FAIL single c=%0d got %b exp %b", c, obs, exp_v[c]);
            end
        end
        control_in = 8'h00;
        tick;
    endtask

    task automatic test_multi;
        control_in = 8'h9A;
        for (int c = 1; c <= 18; c++) begin
            tick;
            checks++;
            if (obs !== exp_w3n2(c)) begin
                errors++;
                $display("FAIL multi c=%0d got %b exp %b", c, obs, exp_w3n2(c));
            end
        end
        control_in = 8'h00;
        tick;
    endtask

    task automatic test_abort;
        logic [6:0] exp;
        control_in = 8'hBF;
        for (int c = 1; c <= 22; c++) begin
            tick;
            exp = {((c >= 1 && c <= 8) || (c >= 11 && c <= 18) || (c >= 21)), 1'b1, 2'b00,
                   ((c <= 10) ? 3'd0 : ((c <= 20) ? 3'd1 : 3'd2))};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL abort_run c=%0d got %b exp %b", c, obs, exp);
            end
        end
        control_in = 8'hFF;
        tick;
        checks++;
        if (obs !== 7'b0001010) begin
            errors++;
            $display("FAIL abort_strobe got %b exp %b", obs, 7'b0001010);
        end
        control_in = 8'h00;
        for (int c = 24; c <= 40; c++) begin
            tick;
            checks++;
            if (obs !== 7'b0000010) begin
                errors++;
                $display("FAIL abort_after c=%0d got %b exp %b", c, obs, 7'b0000010);
            end
        end
    endtask

    task automatic test_start_held;
        control_in = 8'h80;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick;
            checks++;
            if (obs !== 7'b0000000) begin
                errors++;
                $display("FAIL held_start c=%0d got %b exp %b", c, obs, 7'b0000000);
            end
        end
        control_in = 8'h00;
        tick;
        control_in = 8'h80;
        tick;
        checks++;
        if (obs !== 7'b1100000) begin
            errors++;
            $display("FAIL held_restart got %b exp %b", obs, 7'b1100000);
        end
        tick;
        checks++;
        if (obs !== 7'b0010000) begin
            errors++;
            $display("FAIL held_done got %b exp %b", obs, 7'b0010000);
        end
        control_in = 8'h00;
        tick;
        control_in = 8'hC0;
        for (int c = 0; c < 2; c++) begin
            tick;
            checks++;
            if (obs !== 7'b0000000) begin
                errors++;
                $display("FAIL idle_abort c=%0d got %b exp %b", c, obs, 7'b0000000);
            end
        end
        // Abort released with start still high: no fresh edge, no train.
        control_in = 8'h80;
        tick;
        tick;
        checks++;
        if (obs !== 7'b0000000) begin
            errors++;
            $display("FAIL idle_abort_release got %b exp %b", obs, 7'b0000000);
        end
        control_in = 8'h00;
        tick;
    endtask

    task automatic test_back_to_back;
        logic [6:0] exp;
        control_in = 8'h9A;
        for (int c = 1; c <= 19; c++) begin
            tick;
            if (c <= 17)      exp = exp_w3n2(c);
            else if (c == 18) exp = 7'b1100000;
            else              exp = 7'b0010000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL b2b c=%0d got %b exp %b", c, obs, exp);
            end
            if (c == 3)  control_in = 8'h00;
            if (c == 5)  control_in = 8'hBF;
            if (c == 16) control_in = 8'h00;
            if (c == 17) control_in = 8'h80;
        end
        control_in = 8'h00;
        tick;
    endtask

    task automatic test_reset_mid;
        control_in = 8'h9A;
        tick;
        tick;
        checks++;
        if (obs !== 7'b1100000) begin
            errors++;
            $display("FAIL rmid_high got %b exp %b", obs, 7'b1100000);
        end
        reset = 1'b1;
        tick;
        checks++;
        if (obs !== 7'b0000000) begin
            errors++;
            $display("FAIL rmid_reset got %b exp %b", obs, 7'b0000000);
        end
        reset = 1'b0;
        control_in = 8'h00;
        for (int c = 0; c < 4; c++) begin
            tick;
            checks++;
            if (obs !== 7'b0000000) begin
                errors++;
                $display("FAIL rmid_after c=%0d got %b exp %b", c, obs, 7'b0000000);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        control_in = 8'h00;
        test_reset;
        test_single;
        test_multi;
        test_abort;
        test_start_held;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
